// File: rtl/ifmap_window_read_ctrl.sv
// IFMap window read controller: streams buffer words into a circular spad,
// tracks completed rows in a descriptor queue and exposes WIN_ROWS-row windows.
module ifmap_window_read_ctrl #(
    parameter int SPAD_DEPTH = 16,
    parameter int ADDR_W     = $clog2(SPAD_DEPTH),
    parameter int MAX_ROWS   = 4,
    parameter int WIN_ROWS   = 3,
    parameter int STRIDE     = 1,
    parameter int ROW_W      = $clog2(MAX_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              stall,
    input  logic              clr_addr,
    input  logic              buf_valid,
    input  logic              start_row,
    input  logic              end_row,
    input  logic              done,
    output logic              ren_buf,
    output logic              wen_spad,
    output logic [ADDR_W-1:0] spad_waddr,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_start,
    output logic [ADDR_W-1:0] win_end,
    output logic [ROW_W-1:0]  rows_held,
    output logic              spad_full,
    output logic              protocol_err
);
    localparam int OCC_W  = $clog2(SPAD_DEPTH + 1);
    localparam int QIDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WINDOW} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   wptr, wptr_n;
    logic [OCC_W-1:0]    occ, occ_n;
    logic [QIDX_W-1:0]   head, tail, head_n;
    logic [ROW_W-1:0]    rows, rows_n;
    logic                row_open;
    logic [ADDR_W-1:0]   open_start;
    logic [ADDR_W-1:0]   q_start [MAX_ROWS];
    logic [ADDR_W-1:0]   q_end   [MAX_ROWS];
    logic                err;

    logic                queue_full, accept, done_acc, push, err_set;
    logic                anchor_ok;
    logic [ADDR_W-1:0]   anchor, push_start;
    logic [OCC_W-1:0]    a_ext, o_ext, freed;

    // base < MAX_ROWS and off <= MAX_ROWS, so one conditional subtract wraps it
    function automatic logic [QIDX_W-1:0] qidx(input logic [QIDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= MAX_ROWS) s = s - MAX_ROWS;
        return QIDX_W'(s);
    endfunction

    assign queue_full = (rows == ROW_W'(MAX_ROWS));
    assign spad_full  = (occ == OCC_W'(SPAD_DEPTH));
    assign win_valid  = (state == S_WINDOW);
    assign accept     = buf_valid & ~stall & (state != S_IDLE) & ~spad_full
                        & ~(start_row & queue_full);
    assign done_acc   = done & win_valid & ~stall;
    assign push       = accept & end_row & (row_open | start_row);
    assign push_start = start_row ? wptr : open_start;
    assign tail       = qidx(head, int'(rows));
    assign head_n     = qidx(head, STRIDE);
    assign wptr_n     = (wptr == ADDR_W'(SPAD_DEPTH - 1)) ? '0 : wptr + 1'b1;

    assign err_set = ~stall & ((done & ~win_valid)
                     | (accept & start_row & row_open)
                     | (accept & ~row_open & ~start_row));

    // New oldest-word anchor after a pop: next queued row, else the open row,
    // else nothing survives and every resident word is released.
    always_comb begin
        anchor_ok = 1'b0;
        anchor    = '0;
        if (int'(rows) > STRIDE) begin
            anchor_ok = 1'b1;
            anchor    = q_start[head_n];
        end else if (row_open) begin
            anchor_ok = 1'b1;
            anchor    = open_start;
        end
        a_ext = OCC_W'(anchor);
        o_ext = OCC_W'(q_start[head]);
        if (!anchor_ok)
            freed = occ;
        else if (a_ext >= o_ext)
            freed = a_ext - o_ext;
        else
            freed = a_ext + OCC_W'(SPAD_DEPTH) - o_ext;
    end

    always_comb begin
        occ_n  = occ;
        rows_n = rows;
        if (accept) occ_n = occ_n + 1'b1;
        if (done_acc) occ_n = occ_n - freed;
        if (push) rows_n = rows_n + 1'b1;
        if (done_acc) rows_n = rows_n - ROW_W'(STRIDE);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (init && !stall) state_n = S_FILL;
            S_FILL:   if (int'(rows_n) >= WIN_ROWS) state_n = S_WINDOW;
            S_WINDOW: if (int'(rows_n) < WIN_ROWS) state_n = S_FILL;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            occ        <= '0;
            head       <= '0;
            rows       <= '0;
            row_open   <= 1'b0;
            open_start <= '0;
            for (int i = 0; i < MAX_ROWS; i++) begin
                q_start[i] <= '0;
                q_end[i]   <= '0;
            end
        end else if (clr_addr) begin
            state    <= S_IDLE;
            wptr     <= '0;
            occ      <= '0;
            head     <= '0;
            rows     <= '0;
            row_open <= 1'b0;
        end else if (!stall) begin
            state <= state_n;
            occ   <= occ_n;
            rows  <= rows_n;
            if (done_acc) head <= head_n;
            if (accept) begin
                wptr <= wptr_n;
                if (start_row) open_start <= wptr;
                if (end_row && (row_open || start_row))
                    row_open <= 1'b0;
                else if (start_row)
                    row_open <= 1'b1;
            end
            if (push) begin
                q_start[tail] <= push_start;
                q_end[tail]   <= wptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
    end

    assign ren_buf      = accept;
    assign wen_spad     = accept;
    assign spad_waddr   = wptr;
    assign rows_held    = rows;
    assign protocol_err = err;
    assign win_start    = win_valid ? q_start[head] : '0;
    assign win_end      = win_valid ? q_end[qidx(head, WIN_ROWS - 1)] : '0;

endmodule

// File: tb/tb_ifmap_window_read_ctrl.sv
// Scoreboard bench: expected write addresses are queued by the stimulus and
// popped by per-instance monitors; window/status values are checked directly.
module tb_ifmap_window_read_ctrl;
    logic clk, rst;

    logic a_init, a_stall, a_clr, a_bv, a_sr, a_er, a_done;
    logic a_ren, a_wen, a_wv, a_full, a_err;
    logic [2:0] a_waddr, a_ws, a_we, a_rows;

    logic b_init, b_stall, b_clr, b_bv, b_sr, b_er, b_done;
    logic b_ren, b_wen, b_wv, b_full, b_err;
    logic [2:0] b_waddr, b_ws, b_we, b_rows;

    int tests = 0;
    int fails = 0;
    int qa[$];
    int qb[$];

    ifmap_window_read_ctrl #(.SPAD_DEPTH(8), .MAX_ROWS(4), .WIN_ROWS(2), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .init(a_init), .stall(a_stall), .clr_addr(a_clr),
        .buf_valid(a_bv), .start_row(a_sr), .end_row(a_er), .done(a_done),
        .ren_buf(a_ren), .wen_spad(a_wen), .spad_waddr(a_waddr), .win_valid(a_wv),
        .win_start(a_ws), .win_end(a_we), .rows_held(a_rows), .spad_full(a_full),
        .protocol_err(a_err));

    ifmap_window_read_ctrl #(.SPAD_DEPTH(8), .MAX_ROWS(4), .WIN_ROWS(2), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .init(b_init), .stall(b_stall), .clr_addr(b_clr),
        .buf_valid(b_bv), .start_row(b_sr), .end_row(b_er), .done(b_done),
        .ren_buf(b_ren), .wen_spad(b_wen), .spad_waddr(b_waddr), .win_valid(b_wv),
        .win_start(b_ws), .win_end(b_we), .rows_held(b_rows), .spad_full(b_full),
        .protocol_err(b_err));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_ren === 1'b1) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected_write: got addr %0d expected none", a_waddr);
            end else begin
                int e;
                e = qa.pop_front();
                if (int'(a_waddr) != e || a_wen !== 1'b1) begin
                    fails++;
                    $display("FAIL a_write: got addr %0d wen %0b expected addr %0d wen 1",
                             a_waddr, a_wen, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_ren === 1'b1) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected_write: got addr %0d expected none", b_waddr);
            end else begin
                int e;
                e = qb.pop_front();
                if (int'(b_waddr) != e || b_wen !== 1'b1) begin
                    fails++;
                    $display("FAIL b_write: got addr %0d wen %0b expected addr %0d wen 1",
                             b_waddr, b_wen, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input bit v, input bit s, input bit e, input bit d);
        if (i == 0) begin
            a_bv = v; a_sr = s; a_er = e; a_done = d;
        end else begin
            b_bv = v; b_sr = s; b_er = e; b_done = d;
        end
    endtask

    function automatic bit ren(input int i);
        return (i == 0) ? (a_ren === 1'b1) : (b_ren === 1'b1);
    endfunction

    task automatic send(input int i, input bit s, input bit e, input int exp);
        bit got;
        got = 1'b0;
        if (i == 0) qa.push_back(exp); else qb.push_back(exp);
        drv(i, 1'b1, s, e, 1'b0);
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            got = ren(i);
            @(posedge clk);
            #1;
        end
        drv(i, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: inst %0d addr %0d got no accept expected accept", i, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_init = 0; a_stall = 0; a_clr = 0; a_bv = 0; a_sr = 0; a_er = 0; a_done = 0;
        b_init = 0; b_stall = 0; b_clr = 0; b_bv = 0; b_sr = 0; b_er = 0; b_done = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_ren", a_ren, 0);
        chk("rst_wen", a_wen, 0);
        chk("rst_waddr", a_waddr, 0);
        chk("rst_win_valid", a_wv, 0);
        chk("rst_win_start", a_ws, 0);
        chk("rst_win_end", a_we, 0);
        chk("rst_rows", a_rows, 0);
        chk("rst_full", a_full, 0);
        chk("rst_err", a_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // async reset in the middle of filling
        a_init = 1; cyc(); a_init = 0;
        send(0, 1, 0, 0); send(0, 0, 0, 1); send(0, 0, 1, 2);
        chk("midfill_rows", a_rows, 1);
        send(0, 1, 0, 3);
        chk("midfill_waddr", a_waddr, 4);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rows", a_rows, 0);
        chk("async_rst_waddr", a_waddr, 0);
        chk("async_rst_wv", a_wv, 0);
        cyc(); rst = 1'b1;

        // two 3-word rows fill the first window
        a_init = 1; cyc(); a_init = 0;
        send(0, 1, 0, 0); send(0, 0, 0, 1); send(0, 0, 1, 2);
        chk("row0_rows", a_rows, 1);
        chk("row0_wv", a_wv, 0);
        send(0, 1, 0, 3); send(0, 0, 0, 4); send(0, 0, 1, 5);
        chk("win1_valid", a_wv, 1);
        chk("win1_start", a_ws, 0);
        chk("win1_end", a_we, 5);
        chk("win1_rows", a_rows, 2);

        // third row overflows the spad; done frees row 0
        send(0, 1, 0, 6); send(0, 0, 0, 7);
        chk("full_flag", a_full, 1);
        qa.push_back(0);
        drv(0, 1, 0, 1, 1);
        @(negedge clk);
        chk("ren_held_when_full", a_ren, 0);
        @(posedge clk); #1;
        drv(0, 1, 0, 1, 0);
        chk("after_done_full", a_full, 0);
        chk("after_done_wv", a_wv, 0);
        @(negedge clk);
        chk("ren_after_free", a_ren, 1);
        @(posedge clk); #1;
        drv(0, 0, 0, 0, 0);
        chk("win2_valid", a_wv, 1);
        chk("win2_start", a_ws, 3);
        chk("win2_end", a_we, 0);
        chk("win2_rows", a_rows, 2);

        // done and end_row together keep the window
        send(0, 1, 0, 1);
        qa.push_back(2);
        drv(0, 1, 0, 1, 1);
        @(negedge clk);
        chk("same_cycle_ren", a_ren, 1);
        @(posedge clk); #1;
        drv(0, 0, 0, 0, 0);
        chk("same_cycle_rows", a_rows, 2);
        chk("same_cycle_wv", a_wv, 1);
        chk("same_cycle_start", a_ws, 6);
        chk("same_cycle_end", a_we, 2);

        // flush, then protocol errors
        a_clr = 1; cyc(); a_clr = 0;
        chk("clr_rows", a_rows, 0);
        chk("clr_waddr", a_waddr, 0);
        chk("clr_wv", a_wv, 0);
        chk("clr_full", a_full, 0);
        chk("clr_err_clean", a_err, 0);
        a_done = 1; cyc(); a_done = 0;
        chk("err_done_idle", a_err, 1);
        a_clr = 1; cyc(); a_clr = 0;
        chk("err_survives_clr", a_err, 1);
        rst = 1'b0; #1;
        chk("err_cleared_rst", a_err, 0);
        cyc(); rst = 1'b1;
        a_init = 1; cyc(); a_init = 0;
        send(0, 1, 0, 0);
        chk("err_single_start", a_err, 0);
        send(0, 1, 0, 1);
        chk("err_double_start", a_err, 1);
        cyc();
        chk("err_sticky", a_err, 1);
        chk("a_queue_drained", qa.size(), 0);

        // stride 2: four 2-word rows, one done releases two
        b_init = 1; cyc(); b_init = 0;
        send(1, 1, 0, 0); send(1, 0, 1, 1);
        send(1, 1, 0, 2); send(1, 0, 1, 3);
        chk("b_win_valid", b_wv, 1);
        chk("b_win_end_2rows", b_we, 3);
        send(1, 1, 0, 4); send(1, 0, 1, 5);
        send(1, 1, 0, 6); send(1, 0, 1, 7);
        chk("b_rows4", b_rows, 4);
        chk("b_full", b_full, 1);
        chk("b_start_before", b_ws, 0);
        b_done = 1; cyc(); b_done = 0;
        chk("b_start_after", b_ws, 4);
        chk("b_end_after", b_we, 7);
        chk("b_rows_after", b_rows, 2);
        chk("b_full_after", b_full, 0);
        chk("b_wv_after", b_wv, 1);
        b_stall = 1; drv(1, 1, 1, 0, 0); #1;
        chk("b_stall_blocks", b_ren, 0);
        cyc();
        chk("b_stall_waddr", b_waddr, 0);
        drv(1, 0, 0, 0, 0); b_stall = 0;
        chk("b_queue_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
